// File: rtl/fruit_launcher.sv
// Per-launch parameter generator for coord_generator: an LFSR-randomised launch x, y velocity,
// direction and presence flag, regenerated after each new-launch pulse. Optional bomb output: FRUIT_LAUNCHER_BOMB_EN.
module fruit_launcher #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int unsigned X_MIN      = 256,
    parameter int unsigned X_MAX      = 767,
    parameter int unsigned X_MID      = 512,
    parameter int unsigned YVEL_BASE  = 14,
    parameter int unsigned ACT_THRESH = 12
) (
    input  logic       vsync,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       new_launch,
    input  logic [7:0] score,
    output logic [9:0] xcostart,
    output logic [4:0] yvel,
    output logic       backwards,
    output logic       active,
    output logic [7:0] launch_count
`ifdef FRUIT_LAUNCHER_BOMB_EN
    ,
    output logic       bomb
`endif
);

    localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS      = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic        new_d;
    logic        new_rise;
    logic [1:0]  diff;
    logic [10:0] x_sum;
    logic [9:0]  x_gen;
    logic        backwards_gen;
    logic [5:0]  yvel_sum;
    logic [4:0]  yvel_gen;
    logic [4:0]  act_limit;
    logic        active_gen;

    assign new_rise  = new_launch & ~new_d;
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

    // Launch parameters are derived from the pre-advance LFSR value.
    always_comb begin
        diff          = (score[7:4] > 4'd3) ? 2'd3 : score[5:4];
        x_sum         = 11'(X_MIN) + {2'b00, lfsr[8:0]};
        x_gen         = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
        backwards_gen = (x_gen >= 10'(X_MID));
        yvel_sum      = 6'(YVEL_BASE) + {3'b000, lfsr[11:9]} + {4'b0000, diff};
        yvel_gen      = (yvel_sum > 6'd31) ? 5'd31 : yvel_sum[4:0];
        act_limit     = 5'(ACT_THRESH) + {3'b000, diff};
        active_gen    = ({1'b0, lfsr[15:12]} < act_limit);
    end

`ifdef FRUIT_LAUNCHER_BOMB_EN
    logic bomb_gen;
    assign bomb_gen = active_gen & (lfsr[3:0] == 4'h0) & (score >= 8'd16);
`else
    logic unused_score_low;
    assign unused_score_low = ^score[3:0];
`endif

    // Dropping rdy wins over everything else, including a pending new-launch edge.
    always_comb begin
        state_next = state;
        if (!rdy) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = GEN;
                GEN:     state_next = HOLD;
                HOLD:    state_next = new_rise ? GEN : HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge vsync) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= SEED_INIT;
            new_d <= 1'b0;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
            new_d <= new_launch;
        end
    end

    // Outputs are idle defaults whenever not running; launch_count is kept across idle periods.
    always_ff @(posedge vsync) begin
        if (!rst_n) begin
            xcostart     <= 10'(X_MIN);
            yvel         <= 5'(YVEL_BASE);
            backwards    <= 1'b0;
            active       <= 1'b0;
            launch_count <= 8'd0;
`ifdef FRUIT_LAUNCHER_BOMB_EN
            bomb         <= 1'b0;
`endif
        end else if (!rdy || state == IDLE) begin
            xcostart     <= 10'(X_MIN);
            yvel         <= 5'(YVEL_BASE);
            backwards    <= 1'b0;
            active       <= 1'b0;
`ifdef FRUIT_LAUNCHER_BOMB_EN
            bomb         <= 1'b0;
`endif
        end else if (state == GEN) begin
            xcostart     <= x_gen;
            yvel         <= yvel_gen;
            backwards    <= backwards_gen;
            active       <= active_gen;
            launch_count <= launch_count + 8'd1;
`ifdef FRUIT_LAUNCHER_BOMB_EN
            bomb         <= bomb_gen;
`endif
        end
    end

endmodule

// File: tb/tb_fruit_launcher.sv
// Scoreboard bench for fruit_launcher: a default instance and one with a low X_MAX / high YVEL_BASE
// so both saturation paths are exercised. Define FRUIT_LAUNCHER_BOMB_EN to also check bomb.
module tb_fruit_launcher;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       vsync = 1'b0;
    logic       rst_n;
    logic       rdy;
    logic       new_launch;
    logic [7:0] score;

    logic [9:0] xcostart, xcostart_s;
    logic [4:0] yvel, yvel_s;
    logic       backwards, backwards_s;
    logic       active, active_s;
    logic [7:0] launch_count, launch_count_s;
`ifdef FRUIT_LAUNCHER_BOMB_EN
    logic       bomb, bomb_s;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_count = 0;
    int first_x, first_y;
    logic [15:0] m_lfsr = SEED;

    typedef struct {
        int edge_no;
        int cnt;
        int x;
        int y;
        int back;
        int act;
        int bomb;
        int xs;
        int ys;
        int backs;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [7:0] prev_count = 8'd0;
    logic       in_reset;

    always #5 vsync = ~vsync;

    fruit_launcher dut (
        .vsync(vsync), .rst_n(rst_n), .rdy(rdy), .new_launch(new_launch), .score(score),
        .xcostart(xcostart), .yvel(yvel), .backwards(backwards), .active(active),
        .launch_count(launch_count)
`ifdef FRUIT_LAUNCHER_BOMB_EN
        , .bomb(bomb)
`endif
    );

    fruit_launcher #(.X_MAX(600), .YVEL_BASE(28)) dut_sat (
        .vsync(vsync), .rst_n(rst_n), .rdy(rdy), .new_launch(new_launch), .score(score),
        .xcostart(xcostart_s), .yvel(yvel_s), .backwards(backwards_s), .active(active_s),
        .launch_count(launch_count_s)
`ifdef FRUIT_LAUNCHER_BOMB_EN
        , .bomb(bomb_s)
`endif
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Golden launch model, in plain integer arithmetic.
    function automatic void calc(input logic [15:0] l, input int sc, input int x_max, input int ybase,
                                 output int x, output int y, output int back, output int act,
                                 output int bmb);
        int d;
        d = sc / 16;
        if (d > 3) d = 3;
        x = 256 + int'(l[8:0]);
        if (x > x_max) x = x_max;
        back = (x >= 512) ? 1 : 0;
        y = ybase + int'(l[11:9]) + d;
        if (y > 31) y = 31;
        act = (int'(l[15:12]) < 12 + d) ? 1 : 0;
        bmb = (act == 1 && l[3:0] == 4'h0 && sc >= 16) ? 1 : 0;
    endfunction

    always @(posedge vsync) begin
        cyc <= cyc + 1;
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic rdy_v, input logic new_v,
                                 input logic [7:0] sc);
        rst_n      = rst_v;
        rdy        = rdy_v;
        new_launch = new_v;
        score      = sc;
        @(posedge vsync);
        #1;
    endtask

    // Called just after the edge that should trigger GEN on the following edge.
    task automatic push_exp();
        exp_t e;
        int   a2, b2;
        e.edge_no = cyc + 1;
        exp_count = (exp_count + 1) % 256;
        e.cnt     = exp_count;
        calc(m_lfsr, int'(score), 767, 14, e.x, e.y, e.back, e.act, e.bomb);
        calc(m_lfsr, int'(score), 600, 28, e.xs, e.ys, e.backs, a2, b2);
        sb_q.push_back(e);
    endtask

    task automatic check_defaults(input string tag);
        checkOutput({tag, "_x"}, int'(xcostart), 256);
        checkOutput({tag, "_yvel"}, int'(yvel), 14);
        checkOutput({tag, "_back"}, int'(backwards), 0);
        checkOutput({tag, "_active"}, int'(active), 0);
        checkOutput({tag, "_count"}, int'(launch_count), exp_count);
        checkOutput({tag, "_yvel_sat"}, int'(yvel_s), 28);
`ifdef FRUIT_LAUNCHER_BOMB_EN
        checkOutput({tag, "_bomb"}, int'(bomb), 0);
`endif
    endtask

    task automatic start_game(input logic [7:0] sc);
        applyStimulus(1'b1, 1'b1, 1'b0, sc);
        push_exp();
        applyStimulus(1'b1, 1'b1, 1'b0, sc);
        applyStimulus(1'b1, 1'b1, 1'b0, sc);
    endtask

    task automatic pulse(input logic [7:0] sc);
        applyStimulus(1'b1, 1'b1, 1'b1, sc);
        push_exp();
        applyStimulus(1'b1, 1'b1, 1'b0, sc);
        applyStimulus(1'b1, 1'b1, 1'b0, sc);
    endtask

    // Scoreboard consumer: every launch_count change outside reset is one GEN.
    always begin
        @(posedge vsync);
        in_reset = !rst_n;
        #1;
        if (!in_reset && launch_count != prev_count) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_gen", int'(launch_count), int'(prev_count));
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("gen_edge", cyc, mon_e.edge_no);
                checkOutput("launch_count", int'(launch_count), mon_e.cnt);
                checkOutput("xcostart", int'(xcostart), mon_e.x);
                checkOutput("yvel", int'(yvel), mon_e.y);
                checkOutput("backwards", int'(backwards), mon_e.back);
                checkOutput("active", int'(active), mon_e.act);
                checkOutput("xcostart_sat", int'(xcostart_s), mon_e.xs);
                checkOutput("yvel_sat", int'(yvel_s), mon_e.ys);
                checkOutput("backwards_sat", int'(backwards_s), mon_e.backs);
`ifdef FRUIT_LAUNCHER_BOMB_EN
                checkOutput("bomb", int'(bomb), mon_e.bomb);
`endif
            end
        end
        prev_count = launch_count;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached with %0d tests run", tests);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        logic [7:0] score_tab [8];
        score_tab = '{8'h00, 8'h0F, 8'h10, 8'h1F, 8'h20, 8'h35, 8'hFF, 8'h80};

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_defaults("reset");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput("idle_x", int'(xcostart), 256);
            checkOutput("idle_count", int'(launch_count), 0);
        end

        start_game(8'h00);
        first_x = mon_e.x;
        first_y = mon_e.y;
        checkOutput("x_min_limit", (xcostart >= 10'd256) ? 1 : 0, 1);
        checkOutput("x_max_limit", (xcostart <= 10'd767) ? 1 : 0, 1);
        checkOutput("back_rule", int'(backwards), (xcostart >= 10'd512) ? 1 : 0);
        checkOutput("yvel_limits", (yvel >= 5'd14) ? 1 : 0, 1);

        pulse(8'h20);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h35);
        push_exp();
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'h35);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h35);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h35);
        checkOutput("held_once", int'(launch_count), 3);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
        check_defaults("abort");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
        check_defaults("abort_idle");

        start_game(8'hFF);
        for (int i = 0; i < 8; i++) pulse(score_tab[i]);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        exp_count = 0;
        check_defaults("midrun_reset");
        checkOutput("midrun_queue", sb_q.size(), 0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        start_game(8'h00);
        checkOutput("repro_x", int'(xcostart), first_x);
        checkOutput("repro_yvel", int'(yvel), first_y);

        for (int i = 0; i < 255; i++) pulse(score_tab[i % 8]);
        checkOutput("wrap", int'(launch_count), 0);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("queue_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
